product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//   Downstream consumer of multiplier_16bit. Accumulates a stream of 32-bit
//   products into a wide running sum, i.e. the accumulate half of a
//   dot-product / MAC path.
//   A frame ends on in_last, or when MAX_TERMS beats have been accepted.
//   At frame end the sum, term count and overflow flag are presented on a
//   valid/ready output port.
// PARAMETERS
//   PROD_W     32   width of in_product (multiplier output width)
//   ACC_W      40   accumulator width; must be >= PROD_W; sum wraps mod 2**ACC_W
//   MAX_TERMS  256  max beats per frame before forced termination; >= 1
//   CNT_W      $clog2(MAX_TERMS+1)   localparam, width of out_count
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous reset, active-high
//   in_valid      in   1       in_product/in_last valid
//   in_ready      out  1       block can accept a beat
//   in_product    in   PROD_W  unsigned product to accumulate
//   in_last       in   1       accepted beat is the final term of the frame
//   out_valid     out  1       out_sum/out_count/out_overflow valid
//   out_ready     in   1       downstream accepts the result
//   out_sum       out  ACC_W   frame sum mod 2**ACC_W
//   out_count     out  CNT_W   number of terms in the frame (1..MAX_TERMS)
//   out_overflow  out  1       sticky: sum carried out of bit ACC_W-1 during frame
// BEHAVIOUR
//   - States: ACCUM (accepting beats), HOLD (result pending). Reset state is ACCUM.
//   - While rst=1, at the next edge: acc=0, cnt=0, ovf=0, out_valid=0,
//     out_sum=0, out_count=0, out_overflow=0.
//   - in_ready is 0 while rst=1. Otherwise in_ready = (state==ACCUM).
//   - Beat accepted iff in_valid && in_ready. On acceptance:
//     acc <= acc + zero-extended in_product, mod 2**ACC_W; cnt <= cnt+1;
//     ovf <= ovf | carry-out.
//   - When no beat is accepted, in_product and in_last are ignored.
//   - Termination is an accepted beat with in_last=1 OR cnt+1==MAX_TERMS.
//     At the next edge:
//       * out_sum <= final sum including that beat;
//       * out_count <= cnt+1; out_overflow <= final ovf;
//       * out_valid <= 1; state <= HOLD;
//       * acc, cnt and ovf are cleared to 0.
//   - Latency: result visible 1 cycle after the terminating beat.
//   - HOLD: out_* are stable and in_ready=0 until out_valid && out_ready.
//     At that edge: out_valid <= 0 and state <= ACCUM, so in_ready=1 on the
//     following cycle.
//   - After the handshake, out_sum/out_count/out_overflow keep their last values.
//   - Throughput: 1 beat/cycle within a frame; at least 1 idle input cycle
//     per frame (the HOLD cycle).
//   - Single-beat frame (in_last on first beat) gives out_count=1.
//   - Forced termination at MAX_TERMS needs no in_last. The next accepted beat
//     starts a new frame; in_last on the forced beat is equivalent.
//   - out_ready while out_valid=0 has no effect.
//   - rst mid-frame discards the partial sum and count. rst in HOLD drops the
//     pending result (out_valid=0 the next cycle).
//   - No X propagation: all registers have reset values; no latches.
// TESTING
//   1 Reset: rst=1 for 2 cycles -> in_ready=0, out_valid=0, out_sum=0 on
//     those edges; rst=0 -> in_ready=1.
//   2 Basic frame: products 35, 256, 65025, in_last on 3rd, out_ready=1 ->
//     1 cycle later out_valid=1, out_sum=65316, out_count=3, out_overflow=0;
//     in_ready=0 for exactly 1 cycle.
//   3 Backpressure: complete a frame, hold out_ready=0 for 5 cycles with
//     in_valid=1 -> out_* stable, in_ready=0, no beats accepted;
//     out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
//   4 Overflow (ACC_W=33): 3 beats of 32'hFFFE0001, last on 3rd ->
//     out_sum=33'h0FFFA0003, out_overflow=1.
//     The next frame, 1 beat of 5 with last -> out_sum=5, out_overflow=0.
//   5 Forced end (MAX_TERMS=4): 6 beats of value 1, in_last only on 6th ->
//     result A: sum=4, count=4; result B: sum=2, count=2.
//   6 Reset mid-frame: 2 beats of 100, rst for 1 cycle, then 1 beat of 7 with
//     last -> out_sum=7, out_count=1; no result emitted for the aborted frame.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a stream of unsigned products into a wide running sum and
// presents sum, term count and sticky overflow on a valid/ready result port.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        input beat handshake
//   in_product, in_last      product to add, final-term marker
//   out_valid/out_ready      result handshake
//   out_sum                  frame sum mod 2**ACC_W
//   out_count                number of terms in the frame (1..MAX_TERMS)
//   out_overflow             sum carried out of the top bit during the frame
module product_accumulator #(
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 256,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e             r_state;
    state_e             w_next_state;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_term;
    logic [SUM_W-1:0]   w_sum;
    logic               w_carry;
    logic [CNT_W-1:0]   w_cnt_inc;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_term       = 1'b0;
        // One extra bit on the adder exposes the carry-out for the sticky flag.
        w_sum        = {1'b0, r_acc} + SUM_W'(in_product);
        w_carry      = w_sum[ACC_W];
        w_cnt_inc    = r_cnt + CNT_W'(1);

        unique case (r_state)
            ACCUM: begin
                w_in_ready = !rst;
                w_accept   = in_valid && w_in_ready;
                // Frame closes on in_last or when this beat fills the frame.
                w_term     = w_accept &&
                             (in_last || (w_cnt_inc == CNT_W'(MAX_TERMS)));
                if (w_term) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next_state = ACCUM;
                end
            end
            default: begin
                w_next_state = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (w_term) begin
                r_out_sum   <= w_sum[ACC_W-1:0];
                r_out_count <= w_cnt_inc;
                r_out_ovf   <= r_ovf | w_carry;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_cnt <= w_cnt_inc;
                r_ovf <= r_ovf | w_carry;
            end
        end
    end

    assign in_ready     = w_in_ready;
    // A result is pending exactly while the block sits in HOLD.
    assign out_valid    = (r_state == HOLD);
    assign out_sum      = r_out_sum;
    assign out_count    = r_out_count;
    assign out_overflow = r_out_ovf;

endmodule
